card_payment_unit: RTL

Card-side transaction responder for the vending machine. It pairs with the vending FSM: it watches `card_in` and the quoted `cost`, requests authorisation from the external bank link over a req/ack handshake, and drives `valid_tran` back to the vending FSM. It also issues a refund if no vend follows an approved charge.

---
 rtl/vending_pkg.sv | 18 +
 rtl/pay_timer.sv | 31 +++
 rtl/card_payment_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine payment path.
// Contents: card-payment FSM state encoding, datapath widths and the
// default price scaling (cents per cost unit).
package vending_pkg;

   localparam int unsigned COST_W          = 3;
   localparam int unsigned AMT_W           = 8;
   localparam int unsigned PRICE_UNIT_DFLT = 25;

   typedef enum logic [2:0] {
      PS_IDLE  = 3'd0,
      PS_ARMED = 3'd1,
      PS_REQ   = 3'd2,
      PS_GRANT = 3'd3,
      PS_HOLD  = 3'd4
   } pay_state_t;

endpackage

// File: rtl/pay_timer.sv
// Small 4-bit cycle timer shared by the REQ and GRANT timeouts.
// Ports:
//   clock, rst  - clock and synchronous active-high reset
//   clr         - zero the count (used on every state change)
//   en          - count this cycle
//   limit       - runtime terminal count
//   hit         - this enabled cycle is the limit-th one since the last clear
module pay_timer (
   input  logic       clock,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [3:0] limit,
   output logic       hit
);

   logic [3:0] cnt_q;

   always_ff @(posedge clock) begin
      if (rst || clr) begin
         cnt_q <= 4'd0;
      end else if (en && (cnt_q != 4'hF)) begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   // cnt_q holds the cycles already completed, so the current cycle is
   // number cnt_q+1; compare in 5 bits so a limit of 15 cannot wrap.
   assign hit = en && (({1'b0, cnt_q} + 5'd1) == {1'b0, limit});

endmodule

// File: rtl/card_payment_unit.sv
// Card-side transaction responder for the vending machine.
// Watches card_in and the quoted cost, runs a req/ack authorisation with the
// bank link, reports approval to the vending FSM, and refunds approved charges
// that are not followed by a vend.
// Ports:
//   clock, rst          - clock and synchronous active-high reset
//   card_in, cost, vend - from the card slot / vending FSM
//   auth_ack, auth_ok   - bank link response (auth_ok qualified by auth_ack)
//   auth_req, auth_amount - bank link request and amount in cents
//   valid_tran          - payment approved (level)
//   declined, timeout_err, refund - one-cycle pulses
//   busy                - not idle
// All outputs are registered from the next-state decision.
//
// state | meaning
// IDLE  | no card
// ARMED | card present, waiting for a non-zero cost quote
// REQ   | authorisation outstanding, timed by AUTH_TIMEOUT
// GRANT | approved, waiting for vend, timed by VEND_TIMEOUT
// HOLD  | transaction finished, waiting for card removal
module card_payment_unit #(
   parameter int unsigned PRICE_UNIT   = vending_pkg::PRICE_UNIT_DFLT,
   parameter int unsigned AUTH_TIMEOUT = 4,
   parameter int unsigned VEND_TIMEOUT = 8
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       card_in,
   input  logic [2:0] cost,
   input  logic       vend,
   input  logic       auth_ack,
   input  logic       auth_ok,
   output logic       auth_req,
   output logic [7:0] auth_amount,
   output logic       valid_tran,
   output logic       declined,
   output logic       timeout_err,
   output logic       refund,
   output logic       busy
);
   import vending_pkg::*;

   localparam logic [3:0] AUTH_LIM = 4'(AUTH_TIMEOUT);
   localparam logic [3:0] VEND_LIM = 4'(VEND_TIMEOUT);

   pay_state_t state_q, state_d;
   logic       declined_d, timeout_d, refund_d, capture;
   logic       tmr_clr, tmr_en, tmr_hit;
   logic [3:0] tmr_limit;

   assign tmr_en    = (state_q == PS_REQ) || (state_q == PS_GRANT);
   assign tmr_clr   = (state_d != state_q);
   assign tmr_limit = (state_q == PS_REQ) ? AUTH_LIM : VEND_LIM;

   pay_timer u_timer (
      .clock (clock),
      .rst   (rst),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .limit (tmr_limit),
      .hit   (tmr_hit)
   );

   always_comb begin
      state_d    = state_q;
      declined_d = 1'b0;
      timeout_d  = 1'b0;
      refund_d   = 1'b0;
      capture    = 1'b0;
      case (state_q)
         PS_IDLE: begin
            if (card_in) state_d = PS_ARMED;
         end
         PS_ARMED: begin
            // No charge is started once the card has been pulled.
            if (!card_in) begin
               state_d = PS_IDLE;
            end else if (cost != '0) begin
               capture = 1'b1;
               state_d = PS_REQ;
            end
         end
         PS_REQ: begin
            // The handshake always completes; a card pulled meanwhile turns
            // an approval straight into a refund.
            if (auth_ack) begin
               if (!auth_ok) begin
                  declined_d = 1'b1;
                  state_d    = PS_HOLD;
               end else if (card_in) begin
                  state_d = PS_GRANT;
               end else begin
                  refund_d = 1'b1;
                  state_d  = PS_HOLD;
               end
            end else if (tmr_hit) begin
               timeout_d  = 1'b1;
               declined_d = 1'b1;
               state_d    = PS_HOLD;
            end
         end
         PS_GRANT: begin
            if (vend) begin
               state_d = PS_HOLD;
            end else if (tmr_hit || !card_in) begin
               refund_d = 1'b1;
               state_d  = PS_HOLD;
            end
         end
         PS_HOLD: begin
            if (!card_in) state_d = PS_IDLE;
         end
         default: state_d = PS_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= PS_IDLE;
         auth_req    <= 1'b0;
         auth_amount <= '0;
         valid_tran  <= 1'b0;
         declined    <= 1'b0;
         timeout_err <= 1'b0;
         refund      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         auth_req    <= (state_d == PS_REQ);
         valid_tran  <= (state_d == PS_GRANT);
         busy        <= (state_d != PS_IDLE);
         declined    <= declined_d;
         timeout_err <= timeout_d;
         refund      <= refund_d;
         if (capture) auth_amount <= AMT_W'(cost * PRICE_UNIT);
      end
   end

endmodule
